// File: rtl/rr_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter: FSM state encoding and
// the default grant index width.
package rr_arbiter_pkg;

  localparam int DEFAULT_OUT_SIZE = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin winner search: first set request at or above
// ptr, wrapping past the top requester back to 0.
module rr_pick #(
  parameter int OUT_SIZE = 4,
  parameter int IN_SIZE  = 1 << OUT_SIZE
) (
  input  logic [IN_SIZE-1:0]  req,
  input  logic [OUT_SIZE-1:0] ptr,
  output logic [IN_SIZE-1:0]  pick_onehot,
  output logic [OUT_SIZE-1:0] pick_idx,
  output logic                any_req
);

  logic                any_s;
  logic [OUT_SIZE-1:0] idx_s;
  logic [IN_SIZE-1:0]  shifted_s;
  int                  pos_v;

  // Scan requesters in priority order starting at ptr; the first hit wins.
  always_comb begin
    any_s     = 1'b0;
    idx_s     = '0;
    shifted_s = '0;
    pos_v     = 0;
    for (int i = 0; i < IN_SIZE; i++) begin
      pos_v     = (int'(ptr) + i) % IN_SIZE;
      shifted_s = req >> pos_v;
      if (!any_s && shifted_s[0]) begin
        any_s = 1'b1;
        idx_s = OUT_SIZE'(pos_v);
      end else begin
        any_s = any_s;
      end
    end
  end

  assign any_req     = any_s;
  assign pick_idx    = idx_s;
  assign pick_onehot = any_s ? (IN_SIZE'(1'b1) << idx_s) : '0;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a sticky registered grant held until the
// consumer acknowledges it; the pointer advances past each acked winner.
module rr_arbiter
  import rr_arbiter_pkg::*;
#(
  parameter int OUT_SIZE = DEFAULT_OUT_SIZE,
  parameter int IN_SIZE  = 1 << OUT_SIZE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IN_SIZE-1:0]  req,
  input  logic                gnt_ack,
  output logic [IN_SIZE-1:0]  gnt,
  output logic [OUT_SIZE-1:0] gnt_idx,
  output logic                gnt_valid
);

  state_e              state_r;
  logic [OUT_SIZE-1:0] ptr_r;
  logic [IN_SIZE-1:0]  gnt_r;
  logic [OUT_SIZE-1:0] gnt_idx_r;
  logic                gnt_valid_r;

  logic [IN_SIZE-1:0]  pick_onehot_s;
  logic [OUT_SIZE-1:0] pick_idx_s;
  logic                any_req_s;
  logic [OUT_SIZE-1:0] next_ptr_s;

  rr_pick #(
    .OUT_SIZE (OUT_SIZE),
    .IN_SIZE  (IN_SIZE)
  ) u_pick (
    .req         (req),
    .ptr         (ptr_r),
    .pick_onehot (pick_onehot_s),
    .pick_idx    (pick_idx_s),
    .any_req     (any_req_s)
  );

  // Pointer to use after the current grant completes; wraps explicitly so
  // non-power-of-two requester counts stay in range.
  always_comb begin
    if (int'(gnt_idx_r) == IN_SIZE - 1) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = gnt_idx_r + OUT_SIZE'(1'b1);
    end
  end

  // Arbitration FSM: capture a winner in IDLE, hold it until acked in GRANT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      ptr_r       <= '0;
      gnt_r       <= '0;
      gnt_idx_r   <= '0;
      gnt_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            gnt_r       <= pick_onehot_s;
            gnt_idx_r   <= pick_idx_s;
            gnt_valid_r <= 1'b1;
            state_r     <= GRANT;
          end else begin
            state_r     <= IDLE;
          end
        end
        GRANT: begin
          // Ack retires the grant; the idle cycle that follows is the bubble.
          if (gnt_ack) begin
            ptr_r       <= next_ptr_s;
            gnt_r       <= '0;
            gnt_idx_r   <= '0;
            gnt_valid_r <= 1'b0;
            state_r     <= IDLE;
          end else begin
            state_r     <= GRANT;
          end
        end
        default: begin
          state_r     <= IDLE;
          gnt_r       <= '0;
          gnt_idx_r   <= '0;
          gnt_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign gnt       = gnt_r;
  assign gnt_idx   = gnt_idx_r;
  assign gnt_valid = gnt_valid_r;

endmodule

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 Parameter OUT_SIZE, default 4, SHALL set the grant index width.
REQ-002 Parameter IN_SIZE, default 1<<OUT_SIZE, SHALL set the request vector width.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset, sampled on rising clk.
REQ-005 req  input  IN_SIZE  SHALL carry the request lines, one bit per requester.
REQ-006 gnt_ack  input  1  SHALL be the consumer acknowledge, completing the current grant.
REQ-007 gnt  output  IN_SIZE  SHALL be the registered one-hot grant vector, all-zero when no grant is held.
REQ-008 gnt_idx  output  OUT_SIZE  SHALL be the registered binary index of the set bit in gnt.
REQ-009 gnt_valid  output  1  SHALL be high exactly when gnt holds a grant.

Function
REQ-010 Internal state SHALL be a two-state FSM, IDLE and GRANT, plus a round-robin pointer ptr of OUT_SIZE bits.
REQ-011 In IDLE with req == 0, state, ptr and outputs SHALL remain unchanged.
REQ-012 In IDLE with req != 0, the winner SHALL be the first set req bit at or above ptr, searching upward and wrapping from IN_SIZE-1 to 0.
REQ-013 The winner SHALL be registered on the same edge: gnt = one-hot of winner, gnt_idx = winner, gnt_valid = 1, state -> GRANT.
REQ-014 Latency from a req sampled in IDLE to gnt_valid high SHALL be one clock.
REQ-015 In GRANT, gnt, gnt_idx and gnt_valid SHALL stay stable until gnt_ack is sampled high, regardless of req changes, including deassertion of the granted bit.
REQ-016 In GRANT with gnt_ack high, the FSM SHALL set ptr = (gnt_idx + 1) mod IN_SIZE, clear gnt, gnt_idx and gnt_valid, and go to IDLE.
REQ-017 The update in REQ-016 SHALL cause exactly one bubble cycle before the next grant.
REQ-018 gnt_ack sampled while in IDLE SHALL be ignored.
REQ-019 An ack on the first cycle gnt_valid is high SHALL be accepted.
REQ-020 Wrap-around: a winner of IN_SIZE-1 SHALL set ptr to 0.
REQ-021 gnt SHALL never have more than one bit set.
REQ-022 gnt_idx SHALL always equal the bit position of gnt when gnt_valid is high.

Reset
REQ-023 When rst is high, the block SHALL set state = IDLE, ptr = 0, gnt = 0, gnt_idx = 0 and gnt_valid = 0 on that edge.
REQ-024 rst SHALL take priority over req and gnt_ack.
REQ-025 A rst arriving mid-grant SHALL drop the grant with no ptr advance.
REQ-026 The first cycle after rst deasserts SHALL arbitrate normally from ptr = 0.

Structure
REQ-027 A shared package SHALL hold the FSM state enum (IDLE, GRANT) and the default OUT_SIZE constant.
REQ-028 A single combinational sub-module, rr_pick, SHALL be instantiated.
REQ-029 rr_pick SHALL take req and ptr and return the winner as both one-hot and binary index, plus an any-request flag.
REQ-030 All registers SHALL reside in rr_arbiter.

Verification
REQ-031 Reset then single request: rst, then req = 16'h0020 -> next cycle gnt = 16'h0020, gnt_idx = 5, gnt_valid = 1.
REQ-032 Round robin fairness: req = 16'hFFFF held, ack every grant -> gnt_idx sequence 0, 1, 2, …, 15, 0, with gnt_valid low for one cycle between grants.
REQ-033 Wrap search: ptr = 14 (after granting 13), req = 16'h0009 -> gnt_idx = 0, then gnt_idx = 3 after the next ack.
REQ-034 Sticky grant: grant on index 7, deassert req[7], hold gnt_ack = 0 for 5 cycles -> gnt = 16'h0080 stable all 5 cycles; ack -> gnt_valid = 0 next cycle.
REQ-035 Reset mid-grant: grant on index 9, assert rst without ack -> gnt = 0, gnt_valid = 0 next cycle; after release with req = 16'hFFFF -> gnt_idx = 0.
REQ-036 Spurious ack: gnt_ack = 1 in IDLE with req = 0 -> no output change, ptr unchanged; the bench SHALL also check one-hot gnt and the gnt/gnt_idx consistency assertion on every cycle.
